host_ctrl_decoder: RTL and testbench

Parametrised host-side front end for the accelerator. It sits between the BRAM-controller port (byte address, 32-bit data) and the accelerator core, and replaces the pure-combinational address decode of the previous generation. It decodes NUM_REG memory windows plus a CSR window, holds run configuration in registers and generates the start pulse. It tracks run state with an FSM, latches done flags as sticky/W1C bits and drives an interrupt. Read data returns at a fixed latency for every window.

---
 rtl/host_ctrl_pkg.sv | 29 ++
 rtl/rd_lat_pipe.sv | 50 +++++
 rtl/host_ctrl_decoder.sv | 252 +++++++++++++++++++++++++
 tb/tb_host_ctrl_decoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_ctrl_pkg.sv
// Shared definitions for the host control decoder: CSR word map, FSM states, run modes.
package host_ctrl_pkg;

  // CSR word indices inside the CSR window (byte offset >> 2)
  localparam logic [2:0] CSR_CTRL   = 3'd0;  // 0x00
  localparam logic [2:0] CSR_CFG0   = 3'd1;  // 0x04
  localparam logic [2:0] CSR_CFG1   = 3'd2;  // 0x08
  localparam logic [2:0] CSR_STATUS = 3'd3;  // 0x0C
  localparam logic [2:0] CSR_DONE   = 3'd4;  // 0x10
  localparam logic [2:0] CSR_IRQEN  = 3'd5;  // 0x14
  localparam logic [2:0] CSR_CYCLES = 3'd6;  // 0x18
  localparam logic [2:0] CSR_ERR    = 3'd7;  // 0x1C

  // Run modes written to CTRL[1:0]
  localparam logic [1:0] MODE_SA = 2'd1;
  localparam logic [1:0] MODE_FC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMPL = 2'd2
  } fsm_state_e;

  // Error counter sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Fixed-depth valid/ID/data shift register that delays read context so it lines up
// with memory read data. DEPTH = 0 degenerates to a wire.
module rd_lat_pipe #(
  parameter int DEPTH  = 1,
  parameter int ID_W   = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [ID_W-1:0]   i_id,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [ID_W-1:0]   o_id,
  output logic [DATA_W-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    assign o_vld  = i_vld;
    assign o_id   = i_id;
    assign o_data = i_data;
  end else begin : g_pipe
    logic [DEPTH-1:0]             r_vld_pipe;
    logic [DEPTH-1:0][ID_W-1:0]   r_id_pipe;
    logic [DEPTH-1:0][DATA_W-1:0] r_data_pipe;

    // Shift one stage per cycle; stage 0 takes the new request
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld_pipe  <= '0;
        r_id_pipe   <= '0;
        r_data_pipe <= '0;
      end else begin
        r_vld_pipe[0]  <= i_vld;
        r_id_pipe[0]   <= i_id;
        r_data_pipe[0] <= i_data;
        for (int s = 1; s < DEPTH; s++) begin
          r_vld_pipe[s]  <= r_vld_pipe[s-1];
          r_id_pipe[s]   <= r_id_pipe[s-1];
          r_data_pipe[s] <= r_data_pipe[s-1];
        end
      end
    end

    assign o_vld  = r_vld_pipe[DEPTH-1];
    assign o_id   = r_id_pipe[DEPTH-1];
    assign o_data = r_data_pipe[DEPTH-1];
  end

endmodule

// File: rtl/host_ctrl_decoder.sv
// Host-side front end: decodes memory windows and the CSR window from the BRAM-controller
// port, holds run config, sequences runs with a small FSM, and returns read data at a
// fixed latency for every window.
module host_ctrl_decoder
  import host_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 8,
  parameter int PTR_W        = 17,
  parameter int NUM_REG      = 3,
  parameter int REGION_SHIFT = 19,
  parameter int MEM_RD_LAT   = 1,
  parameter int DONE_W       = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         addr_a,
  input  logic [31:0]               wrdata_a,
  output logic [31:0]               rddata_a,
  input  logic                      en_a,
  input  logic [3:0]                we_a,
  output logic [1:0]                start_o,
  output logic [1:0]                nth_conv_o,
  output logic [4:0]                ofmap_size_o,
  output logic [5:0]                ifmap_ch_o,
  output logic [8:0]                in_node_num_o,
  output logic [6:0]                out_node_num_o,
  output logic                      busy_o,
  output logic                      irq_o,
  input  logic [DONE_W-1:0]         done_i,
  output logic [NUM_REG-1:0]        mem_wren_o,
  output logic [NUM_REG-1:0]        mem_rden_o,
  output logic [PTR_W-1:0]          mem_ptr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [NUM_REG*DATA_W-1:0] mem_rdata_i
);

  localparam int RID_W = ADDR_W - REGION_SHIFT;

  // ---------------------------------------------------------------- decode
  logic [RID_W-1:0]   w_rid;
  logic               w_wr, w_rd;
  logic               w_csr_hit, w_csr_off_ok, w_unmapped;
  logic [2:0]         w_csr_idx;
  logic [NUM_REG-1:0] w_win_hit;

  assign w_rid        = addr_a[ADDR_W-1:REGION_SHIFT];
  assign w_wr         = en_a & (|we_a);
  assign w_rd         = en_a & ~(|we_a);
  assign w_csr_hit    = (w_rid == '0);
  assign w_csr_off_ok = (addr_a[REGION_SHIFT-1:5] == '0);
  assign w_csr_idx    = addr_a[4:2];

  for (genvar k = 0; k < NUM_REG; k++) begin : g_win
    assign w_win_hit[k] = (w_rid == RID_W'(k + 1));
  end

  assign w_unmapped = ~w_csr_hit & ~(|w_win_hit);

  // Memory side is purely combinational from the host bus
  assign mem_wren_o  = {NUM_REG{w_wr}} & w_win_hit;
  assign mem_rden_o  = {NUM_REG{w_rd}} & w_win_hit;
  assign mem_ptr_o   = addr_a[PTR_W+1:2];
  assign mem_wdata_o = wrdata_a[DATA_W-1:0];

  // ---------------------------------------------------------------- state
  fsm_state_e        r_state;
  logic [1:0]        r_mode;
  logic [1:0]        r_start;
  logic [31:0]       r_cycles;
  logic              r_complete;
  logic              r_irq;
  logic              r_irq_en;
  logic [12:0]       r_cfg0;
  logic [8:0]        r_cfg1_in;
  logic [6:0]        r_cfg1_out;
  logic [DONE_W-1:0] r_sticky;
  logic [15:0]       r_err;
  logic [31:0]       r_rddata;

  logic w_busy;
  logic w_csr_wr;
  logic w_wr_ctrl, w_wr_cfg0, w_wr_cfg1, w_wr_done, w_wr_irqen;
  logic w_cfg_blocked, w_err_evt, w_start, w_run_exit;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_csr_wr   = w_wr & w_csr_hit & w_csr_off_ok;
  assign w_wr_ctrl  = w_csr_wr & (w_csr_idx == CSR_CTRL);
  assign w_wr_cfg0  = w_csr_wr & (w_csr_idx == CSR_CFG0);
  assign w_wr_cfg1  = w_csr_wr & (w_csr_idx == CSR_CFG1);
  assign w_wr_done  = w_csr_wr & (w_csr_idx == CSR_DONE);
  assign w_wr_irqen = w_csr_wr & (w_csr_idx == CSR_IRQEN);

  // Config is frozen while a run is in flight; attempts count as errors
  assign w_cfg_blocked = w_busy & (w_wr_ctrl | w_wr_cfg0 | w_wr_cfg1);
  assign w_err_evt     = (en_a & w_unmapped) | w_cfg_blocked;
  assign w_start       = w_wr_ctrl & ~w_busy & (wrdata_a[1:0] != 2'd0);

  // Mode 3 is accepted as a start but has no completion condition; only reset ends it
  assign w_run_exit = ((r_mode == MODE_FC) & r_sticky[DONE_W-1]) |
                      ((r_mode == MODE_SA) & (&r_sticky[DONE_W-2:0]));

  // Run FSM: start pulse, cycle counter and completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= 2'd0;
      r_start    <= 2'd0;
      r_cycles   <= 32'd0;
      r_complete <= 1'b0;
    end else begin
      r_start <= 2'd0;
      if (w_wr_done && wrdata_a[31]) r_complete <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_RUN;
            r_mode     <= wrdata_a[1:0];
            r_start    <= wrdata_a[1:0];
            r_cycles   <= 32'd0;
            r_complete <= 1'b0;
          end
        end
        ST_RUN: begin
          r_cycles <= r_cycles + 32'd1;
          if (w_run_exit) r_state <= ST_CMPL;
        end
        ST_CMPL: begin
          // Setting complete here wins over a W1C in the same cycle
          r_complete <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky done flags: OR in pulses every cycle, W1C clear loses to a concurrent pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (w_start) begin
      r_sticky <= done_i;
    end else if (w_wr_done) begin
      r_sticky <= (r_sticky & ~wrdata_a[DONE_W-1:0]) | done_i;
    end else begin
      r_sticky <= r_sticky | done_i;
    end
  end

  // Run configuration and IRQ enable; full-word writes, byte enables ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg0     <= 13'd0;
      r_cfg1_in  <= 9'd0;
      r_cfg1_out <= 7'd0;
      r_irq_en   <= 1'b0;
    end else begin
      if (w_wr_cfg0 && !w_busy) r_cfg0 <= wrdata_a[12:0];
      if (w_wr_cfg1 && !w_busy) begin
        r_cfg1_in  <= wrdata_a[8:0];
        r_cfg1_out <= wrdata_a[22:16];
      end
      if (w_wr_irqen) r_irq_en <= wrdata_a[0];
    end
  end

  // Registered level interrupt and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
      r_err <= 16'd0;
    end else begin
      r_irq <= r_irq_en & r_complete;
      if (w_err_evt) r_err <= sat_inc16(r_err);
    end
  end

  // ---------------------------------------------------------------- read path
  logic [31:0] w_csr_rdata;

  // CSR read value, sampled at request time and carried down the latency pipe
  always_comb begin
    w_csr_rdata = 32'd0;
    if (w_csr_off_ok) begin
      case (w_csr_idx)
        CSR_CFG0:   w_csr_rdata = {19'd0, r_cfg0};
        CSR_CFG1:   w_csr_rdata = {9'd0, r_cfg1_out, 7'd0, r_cfg1_in};
        CSR_STATUS: w_csr_rdata = {29'd0, r_state, w_busy};
        CSR_DONE: begin
          w_csr_rdata[DONE_W-1:0] = r_sticky;
          w_csr_rdata[31]         = r_complete;
        end
        CSR_IRQEN:  w_csr_rdata = {31'd0, r_irq_en};
        CSR_CYCLES: w_csr_rdata = r_cycles;
        CSR_ERR:    w_csr_rdata = {16'd0, r_err};
        default:    w_csr_rdata = 32'd0;
      endcase
    end
  end

  logic              w_pipe_vld;
  logic [RID_W-1:0]  w_pipe_id;
  logic [31:0]       w_pipe_data;
  logic [31:0]       w_rd_word;

  rd_lat_pipe #(
    .DEPTH  (MEM_RD_LAT),
    .ID_W   (RID_W),
    .DATA_W (32)
  ) u_rd_lat_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_rd),
    .i_id   (w_rid),
    .i_data (w_csr_rdata),
    .o_vld  (w_pipe_vld),
    .o_id   (w_pipe_id),
    .o_data (w_pipe_data)
  );

  // Select CSR or zero-extended window data; unmapped regions fall through to 0
  always_comb begin
    w_rd_word = 32'd0;
    if (w_pipe_id == '0) w_rd_word = w_pipe_data;
    for (int k = 0; k < NUM_REG; k++) begin
      if (w_pipe_id == RID_W'(k + 1)) w_rd_word[DATA_W-1:0] = mem_rdata_i[k*DATA_W +: DATA_W];
    end
  end

  // Read data register; holds the last result between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rddata <= 32'd0;
    else if (w_pipe_vld) r_rddata <= w_rd_word;
  end

  // ---------------------------------------------------------------- outputs
  assign rddata_a       = r_rddata;
  assign start_o        = r_start;
  assign nth_conv_o     = r_cfg0[1:0];
  assign ofmap_size_o   = r_cfg0[6:2];
  assign ifmap_ch_o     = r_cfg0[12:7];
  assign in_node_num_o  = r_cfg1_in;
  assign out_node_num_o = r_cfg1_out;
  assign busy_o         = w_busy;
  assign irq_o          = r_irq;

  // Byte-lane bits of the address and spare write-data bits are not decoded
  logic w_unused;
  assign w_unused = ^{addr_a[1:0], wrdata_a};

endmodule

// File: tb/tb_host_ctrl_decoder.sv
// Directed bench for host_ctrl_decoder with a small BRAM model on the memory side.
module tb_host_ctrl_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] addr_a;
  logic [31:0] wrdata_a;
  logic [31:0] rddata_a;
  logic        en_a;
  logic [3:0]  we_a;
  logic [1:0]  start_o;
  logic [1:0]  nth_conv_o;
  logic [4:0]  ofmap_size_o;
  logic [5:0]  ifmap_ch_o;
  logic [8:0]  in_node_num_o;
  logic [6:0]  out_node_num_o;
  logic        busy_o;
  logic        irq_o;
  logic [16:0] done_i;
  logic [2:0]  mem_wren_o;
  logic [2:0]  mem_rden_o;
  logic [16:0] mem_ptr_o;
  logic [7:0]  mem_wdata_o;
  logic [23:0] mem_rdata_i;

  always #5 clk = ~clk;

  host_ctrl_decoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .addr_a         (addr_a),
    .wrdata_a       (wrdata_a),
    .rddata_a       (rddata_a),
    .en_a           (en_a),
    .we_a           (we_a),
    .start_o        (start_o),
    .nth_conv_o     (nth_conv_o),
    .ofmap_size_o   (ofmap_size_o),
    .ifmap_ch_o     (ifmap_ch_o),
    .in_node_num_o  (in_node_num_o),
    .out_node_num_o (out_node_num_o),
    .busy_o         (busy_o),
    .irq_o          (irq_o),
    .done_i         (done_i),
    .mem_wren_o     (mem_wren_o),
    .mem_rden_o     (mem_rden_o),
    .mem_ptr_o      (mem_ptr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // One-cycle-latency BRAM per window; output is 0 when not read so late/early data shows up
  logic [7:0] bmem [3][16];
  logic [7:0] bq   [3];
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bq[k] <= mem_rden_o[k] ? bmem[k][mem_ptr_o[3:0]] : 8'h00;
      if (mem_wren_o[k]) bmem[k][mem_ptr_o[3:0]] <= mem_wdata_o;
    end
  end
  assign mem_rdata_i = {bq[2], bq[1], bq[0]};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] A(input int rid, input int off);
    return 22'((rid << 19) | off);
  endfunction

  task automatic bus_wr(input logic [21:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_a = a; wrdata_a = d; en_a = 1'b1; we_a = 4'hF;
    @(negedge clk);
    en_a = 1'b0; we_a = 4'h0;
  endtask

  task automatic bus_rd(input logic [21:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_a = a; en_a = 1'b1; we_a = 4'h0;
    @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    d = rddata_a;
  endtask

  logic [31:0] rd;
  int          t;

  initial begin
    rst_n = 1'b0; addr_a = '0; wrdata_a = '0; en_a = 1'b0; we_a = '0; done_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_start",  32'(start_o), 32'd0);
    chk("rst_busy",   32'(busy_o), 32'd0);
    chk("rst_irq",    32'(irq_o), 32'd0);
    chk("rst_rddata", rddata_a, 32'd0);
    chk("rst_cfg",    32'({nth_conv_o, ofmap_size_o, ifmap_ch_o, in_node_num_o, out_node_num_o}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Memory write: window 0 (region 1), ptr 5
    addr_a = A(1, 5 << 2); wrdata_a = 32'h0000_00AB; en_a = 1'b1; we_a = 4'hF;
    #1;
    chk("mw_wren",  32'(mem_wren_o), 32'h1);
    chk("mw_rden",  32'(mem_rden_o), 32'h0);
    chk("mw_ptr",   32'(mem_ptr_o), 32'd5);
    chk("mw_wdata", 32'(mem_wdata_o), 32'hAB);
    @(negedge clk);
    en_a = 1'b0; we_a = 4'h0;
    bus_wr(A(1, 6 << 2), 32'h0000_003C);
    bus_wr(A(3, 3 << 2), 32'h0000_00C3);
    bus_rd(A(1, 6 << 2), rd);
    chk("mr_win0_p6", rd, 32'h0000_003C);
    bus_rd(A(1, 5 << 2), rd);
    chk("mr_win0_p5", rd, 32'h0000_00AB);

    // Config + FC run
    bus_wr(A(0, 'h04), 32'h0000_0A35);
    chk("cfg_nth",   32'(nth_conv_o), 32'd1);
    chk("cfg_ofmap", 32'(ofmap_size_o), 32'd13);
    chk("cfg_ifch",  32'(ifmap_ch_o), 32'd20);
    bus_rd(A(0, 'h04), rd);
    chk("cfg0_rd", rd, 32'h0000_0A35);
    bus_wr(A(0, 'h14), 32'h1);
    bus_wr(A(0, 'h00), 32'h0);
    chk("mode0_busy",  32'(busy_o), 32'd0);
    chk("mode0_start", 32'(start_o), 32'd0);

    @(negedge clk);
    addr_a = A(0, 'h00); wrdata_a = 32'h2; en_a = 1'b1; we_a = 4'hF;
    @(negedge clk);
    en_a = 1'b0; we_a = 4'h0;
    chk("fc_start", 32'(start_o), 32'd2);
    chk("fc_busy",  32'(busy_o), 32'd1);
    @(negedge clk);
    chk("fc_start_pulse", 32'(start_o), 32'd0);
    repeat (48) @(negedge clk);
    done_i = 17'h1_0000;
    @(negedge clk);
    done_i = '0;
    chk("fc_run_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("fc_cmpl_busy", 32'(busy_o), 32'd1);
    chk("fc_cmpl_irq",  32'(irq_o), 32'd0);
    @(negedge clk);
    chk("fc_idle_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("fc_irq", 32'(irq_o), 32'd1);
    bus_rd(A(0, 'h0C), rd);
    chk("fc_status", rd, 32'd0);
    bus_rd(A(0, 'h18), rd);
    chk("fc_cycles", rd, 32'd51);
    bus_rd(A(0, 'h10), rd);
    chk("fc_done", rd, 32'h8001_0000);
    bus_wr(A(0, 'h10), 32'h8000_0000);
    @(negedge clk);
    chk("fc_irq_clr", 32'(irq_o), 32'd0);
    bus_rd(A(0, 'h10), rd);
    chk("fc_done_w1c", rd, 32'h0001_0000);
    chk("fc_cfg_stable", 32'(ofmap_size_o), 32'd13);

    // SA run with a blocked CFG1 write
    bus_wr(A(0, 'h08), 32'h002A_0155);
    chk("cfg1_in",  32'(in_node_num_o), 32'h155);
    chk("cfg1_out", 32'(out_node_num_o), 32'h2A);
    bus_wr(A(0, 'h00), 32'h1);
    chk("sa_start", 32'(start_o), 32'd1);
    bus_wr(A(0, 'h08), 32'h0000_0077);
    chk("sa_cfg1_held", 32'(in_node_num_o), 32'h155);
    for (int i = 0; i < 15; i++) begin
      done_i = 17'(1 << i);
      @(negedge clk);
    end
    done_i = '0;
    repeat (3) @(negedge clk);
    chk("sa_still_run", 32'(busy_o), 32'd1);
    done_i = 17'h0_8000;
    @(negedge clk);
    done_i = '0;
    t = 0;
    while (busy_o && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("sa_finish", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("sa_irq", 32'(irq_o), 32'd1);
    bus_rd(A(0, 'h1C), rd);
    chk("sa_err", rd, 32'd1);
    bus_rd(A(0, 'h10), rd);
    chk("sa_done", rd, 32'h8000_FFFF);
    bus_wr(A(0, 'h10), 32'hFFFF_FFFF);
    bus_rd(A(0, 'h10), rd);
    chk("sa_done_clr", rd, 32'd0);

    // Done pulse and W1C in the same cycle: set wins
    @(negedge clk);
    addr_a = A(0, 'h10); wrdata_a = 32'h8; en_a = 1'b1; we_a = 4'hF; done_i = 17'h8;
    @(negedge clk);
    en_a = 1'b0; we_a = 4'h0; done_i = '0;
    bus_rd(A(0, 'h10), rd);
    chk("w1c_set_wins", rd, 32'h8);
    bus_wr(A(0, 'h10), 32'h8);

    // Unmapped accesses
    bus_rd(A(0, 'h04), rd);
    chk("pre_unmap", rd, 32'h0000_0A35);
    @(negedge clk);
    addr_a = A(7, 0); en_a = 1'b1; we_a = 4'h0;
    #1;
    chk("unmap_rden", 32'(mem_rden_o), 32'd0);
    chk("unmap_wren", 32'(mem_wren_o), 32'd0);
    @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    chk("unmap_rd", rddata_a, 32'd0);
    bus_rd(A(0, 'h1C), rd);
    chk("unmap_err_rd", rd, 32'd2);
    bus_wr(A(5, 'h10), 32'h55);
    bus_rd(A(0, 'h1C), rd);
    chk("unmap_err_wr", rd, 32'd3);

    // Back-to-back reads: CSR, window 0, window 2
    @(negedge clk);
    addr_a = A(0, 'h04); en_a = 1'b1; we_a = 4'h0;
    @(negedge clk);
    chk("b2b_lat", rddata_a, 32'd3);
    addr_a = A(1, 5 << 2);
    @(negedge clk);
    chk("b2b_0", rddata_a, 32'h0000_0A35);
    addr_a = A(3, 3 << 2);
    @(negedge clk);
    en_a = 1'b0;
    chk("b2b_1", rddata_a, 32'h0000_00AB);
    @(negedge clk);
    chk("b2b_2", rddata_a, 32'h0000_00C3);

    // Reset in the middle of a run
    bus_wr(A(0, 'h00), 32'h2);
    chk("rr_busy_pre", 32'(busy_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rr_busy",   32'(busy_o), 32'd0);
    chk("rr_start",  32'(start_o), 32'd0);
    chk("rr_irq",    32'(irq_o), 32'd0);
    chk("rr_rddata", rddata_a, 32'd0);
    chk("rr_cfg",    32'({nth_conv_o, ofmap_size_o, ifmap_ch_o, in_node_num_o, out_node_num_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(A(0, 'h0C), rd);
    chk("rr_status", rd, 32'd0);
    bus_rd(A(0, 'h18), rd);
    chk("rr_cycles", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
